// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and glitch-filters the raw pins, deserialises
// 11-bit frames and reports make codes as a single-cycle enable with the scancode.
`timescale 1ns/1ps
module ps2_scancode_rx #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 25000,
    parameter bit          SUPPRESS_BREAK = 1'b1
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       enable,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

    logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic          filt_q;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_flip;
    logic          fall_q;

    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          brk_q, brk_d;
    logic [7:0]    code_q, code_d;
    logic          en_q, en_d;
    logic          err_q, err_d;

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data;
            data_s2_q <= data_s1_q;
        end
    end

    // Level changes on the FILTER_LEN-th consecutive differing sample; the fall is
    // registered on that same edge so the FSM acts exactly one edge later.
    assign filt_flip = (clk_s2_q != filt_q) && (filt_cnt_q == FILT_LAST);

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            fall_q <= filt_flip & filt_q;
            if (clk_s2_q != filt_q) begin
                if (filt_flip) begin
                    filt_q     <= clk_s2_q;
                    filt_cnt_q <= '0;
                end else begin
                    filt_cnt_q <= filt_cnt_q + 1'b1;
                end
            end else begin
                filt_cnt_q <= '0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        to_cnt_d  = to_cnt_q;
        brk_d     = brk_q;
        code_d    = code_q;
        en_d      = 1'b0;
        err_d     = 1'b0;

        if (state_q == StIdle) begin
            to_cnt_d = '0;
        end else if (!fall_q) begin
            if (to_cnt_q == TO_LAST) begin
                state_d  = StIdle;
                to_cnt_d = '0;
                err_d    = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        if (fall_q) begin
            to_cnt_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (!data_s2_q) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    shreg_d   = {data_s2_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = data_s2_q;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (data_s2_q && ((^shreg_q) ^ par_q)) begin
                        if (SUPPRESS_BREAK && (shreg_q == 8'hF0)) begin
                            brk_d = 1'b1;
                        end else if (brk_q) begin
                            brk_d = 1'b0;
                        end else begin
                            code_d = shreg_q;
                            en_d   = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'h00;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            brk_q     <= 1'b0;
            code_q    <= 8'h00;
            en_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
            brk_q     <= brk_d;
            code_q    <= code_d;
            en_q      <= en_d;
            err_q     <= err_d;
        end
    end

    assign scancode  = code_q;
    assign enable    = en_q;
    assign frame_err = err_q;

endmodule
